// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the hazard logic around it.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO holding registers.
// Results are computed at accept into a shadow pair and committed when the countdown expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = MDU_MULT_CYC,
  parameter int DIV_CYC  = MDU_DIV_CYC,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  logic [CNT_W-1:0]   cnt;
  logic [31:0]        shadow_hi;
  logic [31:0]        shadow_lo;
  logic               commit_en;
  logic               accept;
  logic               is_mul;
  logic               is_div;
  logic               is_signed;
  logic signed [32:0] op_a;
  logic signed [32:0] op_b;
  logic signed [32:0] div_b;
  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic [63:0]        product;
  logic [31:0]        quot;
  logic [31:0]        rem;

  assign busy      = (cnt != '0);
  assign accept    = start & ~busy;
  assign is_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

  // 33-bit operands let one signed multiplier/divider serve both signed and unsigned ops
  assign op_a    = is_signed ? {rs_val[31], rs_val} : {1'b0, rs_val};
  assign op_b    = is_signed ? {rt_val[31], rt_val} : {1'b0, rt_val};
  assign mul_a   = 64'(op_a);
  assign mul_b   = 64'(op_b);
  assign product = mul_a * mul_b;

  // divisor forced nonzero so the shadow is never X; the commit is masked instead
  assign div_b = (rt_val == 32'd0) ? 33'sd1 : op_b;
  assign quot  = 32'(op_a / div_b);
  assign rem   = 32'(op_a % div_b);

  assign stall_req = d_is_md & (busy | (start & (is_mul | is_div)));

  always_comb begin
    md_rdata = 32'd0;
    if (md_op == MD_MFHI)      md_rdata = hi;
    else if (md_op == MD_MFLO) md_rdata = lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      commit_en <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        {shadow_hi, shadow_lo} <= product;
        commit_en              <= 1'b1;
        cnt                    <= CNT_W'(MULT_CYC);
      end else if (is_div) begin
        shadow_hi <= rem;
        shadow_lo <= quot;
        commit_en <= (rt_val != 32'd0);
        cnt       <= CNT_W'(DIV_CYC);
      end else if (md_op == MD_MTHI) begin
        hi <= rs_val;
      end else if (md_op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if ((cnt == CNT_W'(1)) && commit_en) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end
    end
  end

endmodule
